// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse on the shared open-drain
// line with the 80/80 us acknowledge and a 40-bit measurement frame.
`timescale 1ns/1ps
module dht11_responder #(
  parameter int CNT_1US_MAX   = 100,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  inout  wire         dht11_data,
  input  logic [31:0] meas_data,
  input  logic        crc_err_inj,
  output logic        busy,
  output logic        done
);

  localparam int PW   = (CNT_1US_MAX > 1) ? $clog2(CNT_1US_MAX) : 1;
  localparam int US_W = 15;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HOST_LOW = 3'd1;
  localparam logic [2:0] RESP_DLY = 3'd2;
  localparam logic [2:0] ACK_LOW  = 3'd3;
  localparam logic [2:0] ACK_HIGH = 3'd4;
  localparam logic [2:0] BIT_LOW  = 3'd5;
  localparam logic [2:0] BIT_HIGH = 3'd6;
  localparam logic [2:0] END_LOW  = 3'd7;

  localparam int T_ACK_US  = 80;
  localparam int T_LOW_US  = 50;
  localparam int T_ZERO_US = 26;
  localparam int T_ONE_US  = 70;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic            bus_p0;
  logic            bus_p1;
  logic            bus_p2;
  logic            bus_fall;
  logic            bus_rise;
  logic [PW-1:0]   pre_cnt;
  logic [US_W-1:0] us_cnt;
  logic [US_W-1:0] us_last;
  logic            us_tick;
  logic            tmo;
  logic            accept;
  logic [39:0]     shreg;
  logic [5:0]      bit_idx;
  logic            drive_low;

  // Byte-sum checksum with optional LSB corruption for host error-path testing.
  function automatic logic [7:0] checksum(input logic [31:0] m, input logic inj);
    logic [7:0] s;
    s = m[31:24] + m[23:16] + m[15:8] + m[7:0];
    return {s[7:1], s[0] ^ inj};
  endfunction

  // Saturating increment so very long start pulses still qualify.
  function automatic logic [US_W-1:0] sat_inc(input logic [US_W-1:0] v);
    return (v == {US_W{1'b1}}) ? v : v + {{(US_W-1){1'b0}}, 1'b1};
  endfunction

  assign dht11_data = drive_low ? 1'b0 : 1'bz;

  assign bus_fall = bus_p2 & ~bus_p1;
  assign bus_rise = ~bus_p2 & bus_p1;
  assign us_tick  = (pre_cnt == PW'(CNT_1US_MAX - 1));
  assign tmo      = us_tick && (us_cnt == us_last);
  assign accept   = (state == HOST_LOW) && bus_rise &&
                    (us_cnt >= US_W'(START_MIN_US));

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus_p0 <= 1'b1;
      bus_p1 <= 1'b1;
      bus_p2 <= 1'b1;
    end else begin
      bus_p0 <= dht11_data;
      bus_p1 <= bus_p0;
      bus_p2 <= bus_p1;
    end
  end

  // Last microsecond index of each timed state (duration minus one).
  always_comb begin
    us_last = {US_W{1'b1}};
    case (state)
      RESP_DLY: us_last = US_W'(RESP_DELAY_US - 1);
      ACK_LOW,
      ACK_HIGH: us_last = US_W'(T_ACK_US - 1);
      BIT_LOW,
      END_LOW:  us_last = US_W'(T_LOW_US - 1);
      BIT_HIGH: us_last = shreg[39] ? US_W'(T_ONE_US - 1) : US_W'(T_ZERO_US - 1);
      default:  us_last = {US_W{1'b1}};
    endcase
  end

  // Next-state logic; the bus is only observed before the acknowledge starts.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus_fall) state_nx = HOST_LOW;
      HOST_LOW: if (bus_rise) state_nx = accept ? RESP_DLY : IDLE;
      RESP_DLY: begin
        if (!bus_p1)  state_nx = HOST_LOW;
        else if (tmo) state_nx = ACK_LOW;
      end
      ACK_LOW:  if (tmo) state_nx = ACK_HIGH;
      ACK_HIGH: if (tmo) state_nx = BIT_LOW;
      BIT_LOW:  if (tmo) state_nx = BIT_HIGH;
      BIT_HIGH: if (tmo) state_nx = (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
      END_LOW:  if (tmo) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  // Microsecond timebase, restarted on every state change.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || (state_nx != state)) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else if (us_tick) begin
      pre_cnt <= '0;
      us_cnt  <= sat_inc(us_cnt);
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Frame shift register, bit counter, bus driver and status flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg     <= '0;
      bit_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drive_low <= 1'b0;
    end else begin
      done      <= (state == END_LOW) && tmo;
      drive_low <= (state_nx == ACK_LOW) || (state_nx == BIT_LOW) ||
                   (state_nx == END_LOW);
      if (accept) begin
        shreg <= {meas_data, checksum(meas_data, crc_err_inj)};
        busy  <= 1'b1;
      end
      if ((state == RESP_DLY) && (state_nx == HOST_LOW)) busy <= 1'b0;
      if ((state == ACK_HIGH) && tmo) bit_idx <= '0;
      if ((state == BIT_HIGH) && tmo) begin
        shreg   <= {shreg[38:0], 1'b0};
        bit_idx <= bit_idx + 6'd1;
      end
      if ((state == END_LOW) && tmo) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: acts as the DHT11 host, decodes the
// returned bus waveform and compares frames against a queue of expectations.
`timescale 1ns/1ps
module tb_dht11_responder;

  localparam int C    = 2;
  localparam int SMIN = 50;
  localparam int RD   = 15;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] meas_data = '0;
  logic        crc_err_inj = 1'b0;
  logic        busy;
  logic        done;
  logic        host_low = 1'b0;
  wire         dht11_data;

  pullup (dht11_data);
  assign dht11_data = host_low ? 1'b0 : 1'bz;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int low_cnt = 0;
  logic [39:0] exp_q[$];

  dht11_responder #(
    .CNT_1US_MAX  (C),
    .START_MIN_US (SMIN),
    .RESP_DELAY_US(RD)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .dht11_data (dht11_data),
    .meas_data  (meas_data),
    .crc_err_inj(crc_err_inj),
    .busy       (busy),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  // Event counters sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (dht11_data === 1'b0 && !host_low) low_cnt <= low_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Counts consecutive negedge samples at lvl; starts on the current sample.
  task automatic measure(input logic lvl, output int w);
    w = 0;
    while (dht11_data === lvl && w < 400 * C) begin
      w++;
      @(negedge sys_clk);
    end
  endtask

  // Host start pulse then release; returns cycles until the bus is pulled low.
  task automatic start_and_wait(input int low_us, output int n);
    host_low = 1'b1;
    repeat (low_us * C) @(negedge sys_clk);
    host_low = 1'b0;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (dht11_data !== 1'b0 && n < RD * C + 50);
  endtask

  task automatic run_frame(input logic [31:0] m, input logic inj, input logic [39:0] exp,
                           input int abort_bit, input bit chg, input string nm);
    int n, w, tim_err, d0, l0;
    logic [39:0] got;
    logic [39:0] want;
    logic b;
    meas_data   = m;
    crc_err_inj = inj;
    exp_q.push_back(exp);
    start_and_wait(SMIN + 10, n);
    check_rng({nm, "_resp_gap"}, n, RD * C + 3, RD * C + 4);
    check({nm, "_busy_in_frame"}, busy, 1'b1);
    if (chg) begin
      meas_data   = ~m;
      crc_err_inj = ~inj;
    end
    measure(1'b0, w);
    check({nm, "_ack_low"}, w, 80 * C);
    measure(1'b1, w);
    check({nm, "_ack_high"}, w, 80 * C);
    tim_err = 0;
    got = '0;
    d0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      measure(1'b0, w);
      if (w != 50 * C) tim_err++;
      if (i == abort_bit) begin
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check({nm, "_rst_busy"}, busy, 1'b0);
        check({nm, "_rst_done"}, done, 1'b0);
        check({nm, "_rst_bus"}, dht11_data, 1'b1);
        sys_rst = 1'b0;
        l0 = low_cnt;
        repeat (300) @(negedge sys_clk);
        check({nm, "_no_resume"}, low_cnt - l0, 0);
        check({nm, "_bit_timing_pre_rst"}, tim_err, 0);
        want = exp_q.pop_front();
        return;
      end
      measure(1'b1, w);
      b = (w > 48 * C);
      if (w != (b ? 70 * C : 26 * C)) tim_err++;
      got = {got[38:0], b};
    end
    measure(1'b0, w);
    check({nm, "_end_low"}, w, 50 * C);
    check({nm, "_done_hi"}, done, 1'b1);
    check({nm, "_busy_end"}, busy, 1'b0);
    @(negedge sys_clk);
    check({nm, "_done_lo"}, done, 1'b0);
    check({nm, "_done_pulses"}, done_cnt - d0, 1);
    check({nm, "_bit_timing"}, tim_err, 0);
    want = exp_q.pop_front();
    check({nm, "_frame"}, got, want);
  endtask

  initial begin
    int n, d0, b0, l0;
    repeat (5) @(negedge sys_clk);
    check("rst_bus", dht11_data, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);

    // Nominal frame; inputs change after the latch and must not matter.
    run_frame(32'h37001A05, 1'b0, 40'h37001A0556, -1, 1'b1, "f1");
    repeat (20) @(negedge sys_clk);

    // Short host pulse: no response at all.
    d0 = done_cnt; b0 = busy_cnt; l0 = low_cnt;
    host_low = 1'b1;
    repeat (20 * C) @(negedge sys_clk);
    host_low = 1'b0;
    repeat (RD * C + 300) @(negedge sys_clk);
    check("glitch_bus_driven", low_cnt - l0, 0);
    check("glitch_busy", busy_cnt - b0, 0);
    check("glitch_done", done_cnt - d0, 0);

    run_frame(32'h00000000, 1'b1, 40'h0000000001, -1, 1'b0, "f2");
    repeat (20) @(negedge sys_clk);
    run_frame(32'hFFFFFFFF, 1'b0, 40'hFFFFFFFFFC, -1, 1'b0, "f3");
    repeat (20) @(negedge sys_clk);

    // Reset during bit 20 high time, then a clean frame.
    run_frame(32'h37001A05, 1'b0, 40'h37001A0556, 20, 1'b0, "f4");
    repeat (20) @(negedge sys_clk);
    run_frame(32'h2A001903, 1'b0, 40'h2A00190346, -1, 1'b0, "f5");
    repeat (20) @(negedge sys_clk);

    // Reset while the responder is actively pulling the bus low.
    meas_data = 32'h12345678;
    start_and_wait(SMIN + 10, n);
    check_rng("ackrst_resp_gap", n, RD * C + 3, RD * C + 4);
    repeat (10) @(negedge sys_clk);
    check("ackrst_bus_low_before", dht11_data, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("ackrst_bus_released", dht11_data, 1'b1);
    check("ackrst_busy", busy, 1'b0);
    sys_rst = 1'b0;
    l0 = low_cnt;
    repeat (200) @(negedge sys_clk);
    check("ackrst_no_resume", low_cnt - l0, 0);

    run_frame(32'h00000000, 1'b0, 40'h0000000000, -1, 1'b0, "f6");
    repeat (10) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol driven by our DHT11 host controller. Detects the host start pulse on the shared open-drain line, answers with the 80 us/80 us acknowledge, then transmits a 40-bit frame (humidity int/dec, temperature int/dec, checksum) using DHT11 bit timing. It sits in board-level test benches and the loop-back test design so the host path can be exercised without a physical sensor.

## Interface
- CNT_1US_MAX, 100: sys_clk cycles per microsecond.
- START_MIN_US, 18000: minimum host-low time (us) accepted as a start request.
- RESP_DELAY_US, 15: bus-release gap (us) between host release and acknowledge low.
- sys_clk  input  1  system clock; one clock domain.
- sys_rst  input  1  synchronous, active-high reset.
- dht11_data  inout  1  open-drain bus; driven 0 or released (z); external pull-up.
- meas_data  input  32  {hum_int, hum_dec, temp_int, temp_dec}, latched at start acceptance.
- crc_err_inj  input  1  when 1 at latch time, checksum LSB is inverted.
- busy  output  1  high from start acceptance to end of frame.
- done  output  1  one-cycle pulse when the frame's final low ends.

## Operation
- Bus input passes a 2-flop synchronizer (reset value 1); edges detected on synchronized value.
- Timebase: prescaler 0..CNT_1US_MAX-1 produces a us tick; us counter (15 bits, saturating) and prescaler both clear on every state change. "N us" means exactly N*CNT_1US_MAX cycles in that state.
- Drive: dht11_data = drive_low ? 0 : z; drive_low is a register. Responder never drives 1.
- States:
  - IDLE: released. Sync negedge -> HOST_LOW.
  - HOST_LOW: released, counting. Sync posedge: us >= START_MIN_US -> latch shreg = {meas_data, checksum}, busy=1, -> RESP_DLY; else -> IDLE (glitch, no response).
  - RESP_DLY: released for RESP_DELAY_US -> ACK_LOW. Sync low seen here -> HOST_LOW (host restarted), busy=0.
  - ACK_LOW: drive 0 for 80 us -> ACK_HIGH.
  - ACK_HIGH: released 80 us -> BIT_LOW, bit_idx=0.
  - BIT_LOW: drive 0 for 50 us -> BIT_HIGH.
  - BIT_HIGH: released 26 us if shreg[39]=0, 70 us if 1; then shift left, bit_idx+1; bit_idx was 39 -> END_LOW else BIT_LOW.
  - END_LOW: drive 0 for 50 us -> IDLE, done=1 for one cycle, busy=0.
- Bus input ignored in ACK_LOW..END_LOW (no collision detection).
- Checksum = (b3+b2+b1+b0) mod 256 of meas_data, LSB XOR crc_err_inj. MSB of frame first.
- meas_data/crc_err_inj changes after latch do not affect the frame in flight.
- Undefined state encodings -> IDLE.

## Timing
- Reset: state IDLE, drive_low=0 (bus released), busy=0, done=0, shreg=0, counters 0. Reset mid-frame releases the bus on the first sys_clk edge with sys_rst high; no partial frame resumes.
- Bus edge to state reaction: 2 cycles (synchronizer) + 1 (edge detect).
- Host release to acknowledge low: RESP_DELAY_US us + 3-4 cycles; must stay below 20 us for the host.
- Full frame after release: RESP_DELAY_US + 160 + 40*50 + sum(high times) + 50 us.
- busy rises the cycle after start acceptance; done coincides with bus release after END_LOW.
- Start held longer than counter range saturates and still qualifies.

## Test plan
- Host low 20 ms then release, meas_data=32'h37001A05, crc_err_inj=0 -> ack 80/80 us, bit stream 40'h37001A0556, done one pulse, busy low afterward.
- Host low 5 ms then release -> bus never driven, busy stays 0, done never pulses.
- meas_data=32'h00000000, crc_err_inj=1 -> frame 40'h0000000001; with 32'hFFFFFFFF, crc_err_inj=0 -> checksum 8'hFC.
- Measure widths on a '1' and '0' bit at CNT_1US_MAX=100 -> high 7000 and 2600 cycles, low 5000 cycles exactly.
- Change meas_data mid-frame; assert sys_rst during BIT_HIGH of bit 20 -> frame unaffected by change; reset releases bus next edge, state IDLE; following start yields a complete correct frame.
- Connect to the team's DHT11 host controller (reduced 2 s/20 ms counts), meas_data=32'h2A001903 -> host t_h_data = 40'h2A00190346 after one cycle of its state machine.
